// File: rtl/iop_pkg.sv
// rtl/iop_pkg.sv - shared function codes, condition codes and FSM state for iop_dispatch
package iop_pkg;

  localparam logic [2:0] IOP_NOP = 3'd0;
  localparam logic [2:0] IOP_SIO = 3'd1;
  localparam logic [2:0] IOP_TIO = 3'd2;
  localparam logic [2:0] IOP_TDV = 3'd3;
  localparam logic [2:0] IOP_HIO = 3'd4;
  localparam logic [2:0] IOP_AIO = 3'd5;

  localparam logic [1:0] CC_NO_ADDR = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

  function automatic logic func_is_io(input logic [2:0] f);
    return (f == IOP_SIO) || (f == IOP_TIO) || (f == IOP_TDV) ||
           (f == IOP_HIO) || (f == IOP_AIO);
  endfunction

endpackage

// File: rtl/iop_rr_arbiter.sv
// rtl/iop_rr_arbiter.sv - registered memory-bus arbiter: IOPs round-robin over CPU, burst limit, turnaround
module iop_rr_arbiter #(
  parameter logic [0:7] PRESENT   = 8'b1000_0000,
  parameter int         MAX_BURST = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:7] iop_req,
  input  logic       cpu_req,
  output logic [0:7] iop_grant,
  output logic       cpu_grant
);

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic          held_q, held_d, cpu_q, cpu_d, owed_q, owed_d;
  logic [2:0]    idx_q, idx_d, ptr_q, ptr_d, cand, rr_idx;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [0:7]    req_m, self_m;
  logic          rr_found, holder_req, others;

  assign req_m  = iop_req & PRESENT;
  assign self_m = 8'b1000_0000 >> idx_q;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!rr_found && req_m[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign holder_req = cpu_q ? cpu_req : req_m[idx_q];
  assign others     = cpu_q ? (|req_m) : (cpu_req || (|(req_m & ~self_m)));

  // Every release goes through an empty cycle; new grants are only made from the empty state.
  always_comb begin
    held_d = held_q;
    cpu_d  = cpu_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    owed_d = owed_q;
    if (held_q) begin
      if (!holder_req || (others && cnt_q >= BURST_MAX)) begin
        held_d = 1'b0;
        cnt_d  = '0;
        if (!cpu_q) owed_d = cpu_req;
      end else if (cnt_q < BURST_MAX) begin
        cnt_d = cnt_q + BW'(1);
      end
    end else if (owed_q && cpu_req) begin
      held_d = 1'b1;
      cpu_d  = 1'b1;
      cnt_d  = BW'(1);
      owed_d = 1'b0;
    end else if (rr_found) begin
      held_d = 1'b1;
      cpu_d  = 1'b0;
      idx_d  = rr_idx;
      ptr_d  = rr_idx;
      cnt_d  = BW'(1);
      owed_d = 1'b0;
    end else if (cpu_req) begin
      held_d = 1'b1;
      cpu_d  = 1'b1;
      cnt_d  = BW'(1);
      owed_d = 1'b0;
    end else begin
      owed_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_q <= 1'b0;
      cpu_q  <= 1'b0;
      owed_q <= 1'b0;
      idx_q  <= 3'd0;
      ptr_q  <= 3'd7;
      cnt_q  <= '0;
    end else begin
      held_q <= held_d;
      cpu_q  <= cpu_d;
      owed_q <= owed_d;
      idx_q  <= idx_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    iop_grant = (held_q && !cpu_q) ? self_m : 8'b0;
    cpu_grant = held_q && cpu_q;
  end

endmodule

// File: rtl/iop_dispatch.sv
// rtl/iop_dispatch.sv - CPU I/O command dispatch to IOPs plus memory-bus arbitration
// Optional per-command statistics outputs when IOP_DISPATCH_STATS_EN is defined.
module iop_dispatch
  import iop_pkg::*;
#(
  parameter logic [0:7] IOP_PRESENT = 8'b1000_0000,
  parameter int         RESP_LAT    = 2,
  parameter int         MAX_BURST   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_io_start,
  input  logic [0:2] cpu_io_func,
  input  logic [0:2] cpu_io_addr,
  output logic       cpu_io_busy,
  output logic       cpu_io_done,
  output logic [0:1] cpu_io_cc,
  output logic [0:2] iop_func,
  output logic [0:2] iop_addr,
  input  logic [0:1] iop_cc,
  input  logic [0:7] iop_dma_req,
  output logic [0:7] iop_active,
  input  logic       cpu_mem_req,
  output logic       cpu_mem_grant
`ifdef IOP_DISPATCH_STATS_EN
  ,
  output logic [0:15] stat_cmds,
  output logic [0:15] stat_rejects
`endif
);

  localparam int            LW       = $clog2(RESP_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(RESP_LAT - 1);

  state_t        state_q, state_d;
  logic [2:0]    func_q, addr_q;
  logic [1:0]    cc_q;
  logic [LW-1:0] lat_q;
  logic          accept, cmd_ok, lat_last;

  assign accept   = (state_q == ST_IDLE) && cpu_io_start;
  assign cmd_ok   = func_is_io(cpu_io_func) && IOP_PRESENT[cpu_io_addr];
  assign lat_last = (lat_q == LAT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cpu_io_start) state_d = cmd_ok ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (lat_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_io_busy = (state_q != ST_IDLE);
    cpu_io_done = (state_q == ST_DONE);
    cpu_io_cc   = cc_q;
    iop_func    = (state_q == ST_ISSUE) ? func_q : IOP_NOP;
    iop_addr    = (state_q == ST_ISSUE) ? addr_q : 3'd0;
  end

  // The cc register changes only when DONE is entered, so it holds between completions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      func_q <= 3'd0;
      addr_q <= 3'd0;
      cc_q   <= 2'b00;
      lat_q  <= '0;
    end else if (accept) begin
      func_q <= cpu_io_func;
      addr_q <= cpu_io_addr;
      lat_q  <= '0;
      if (!cmd_ok) cc_q <= CC_NO_ADDR;
    end else if (state_q == ST_ISSUE) begin
      if (lat_last) cc_q <= iop_cc;
      else          lat_q <= lat_q + LW'(1);
    end
  end

`ifdef IOP_DISPATCH_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cmds    <= 16'd0;
      stat_rejects <= 16'd0;
    end else if (accept) begin
      if (cmd_ok && stat_cmds != 16'hFFFF)     stat_cmds    <= stat_cmds + 16'd1;
      if (!cmd_ok && stat_rejects != 16'hFFFF) stat_rejects <= stat_rejects + 16'd1;
    end
  end
`endif

  iop_rr_arbiter #(
    .PRESENT   (IOP_PRESENT),
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .iop_req   (iop_dma_req),
    .cpu_req   (cpu_mem_req),
    .iop_grant (iop_active),
    .cpu_grant (cpu_mem_grant)
  );

endmodule
